// File: rtl/d5m_camera_frame_gen_if.sv
// rtl/d5m_camera_frame_gen_if.sv - D5M camera stream and status bundle between the emulator and its consumer
`timescale 1ns/1ps

interface d5m_camera_frame_gen_if #(
  parameter int DATA_WIDTH = 12,
  parameter int FCNT_WIDTH = 16
);
  logic                  enable;
  logic                  ifval;
  logic                  ilval;
  logic [DATA_WIDTH-1:0] idata;
  logic                  busy;
  logic                  frame_done;
  logic [FCNT_WIDTH-1:0] frame_count;

  modport master (
    input  enable,
    output ifval, ilval, idata, busy, frame_done, frame_count
  );

  modport slave (
    output enable,
    input  ifval, ilval, idata, busy, frame_done, frame_count
  );
endinterface

// File: rtl/d5m_camera_frame_gen.sv
// rtl/d5m_camera_frame_gen.sv - D5M sensor emulator driving ifval/ilval/idata frames; D5M_CAMERA_LFSR_DATA_EN selects LFSR payload
`timescale 1ns/1ps

module d5m_camera_frame_gen #(
  parameter int DATA_WIDTH = 12,
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 8,
  parameter int FVLV_DLY   = 2,
  parameter int HBLANK     = 4,
  parameter int VBLANK     = 6,
  parameter int FCNT_WIDTH = 16
) (
  input  logic                    pixclk,
  input  logic                    reset,
  d5m_camera_frame_gen_if.master  cam
);

  localparam int XW   = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int YW   = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int PMAX = (FVLV_DLY > HBLANK) ? ((FVLV_DLY > VBLANK) ? FVLV_DLY : VBLANK)
                                            : ((HBLANK > VBLANK) ? HBLANK : VBLANK);
  localparam int PW   = (PMAX > 1) ? $clog2(PMAX) : 1;

  if ((DATA_WIDTH < 1) || (IMG_WIDTH < 1) || (IMG_HEIGHT < 1) || (FVLV_DLY < 1) ||
      (HBLANK < 1) || (VBLANK < 1) || (FCNT_WIDTH < 1)) begin : g_param_check
    $fatal(1, "d5m_camera_frame_gen: every size/timing parameter must be >= 1");
  end

  typedef enum logic [2:0] {S_IDLE, S_FSTART, S_LINE, S_HB, S_VB} state_e;

  state_e                state_q, state_d;
  logic [XW-1:0]         x_q, x_d;
  logic [YW-1:0]         y_q, y_d;
  logic [PW-1:0]         cnt_q, cnt_d;
  logic                  ifval_q, ifval_d;
  logic                  ilval_q, ilval_d;
  logic [DATA_WIDTH-1:0] idata_q, idata_d;
  logic                  busy_q, busy_d;
  logic                  frame_done_q, frame_done_d;
  logic [FCNT_WIDTH-1:0] frame_count_q, frame_count_d;
`ifdef D5M_CAMERA_LFSR_DATA_EN
  logic [11:0]           lfsr_q, lfsr_d;
`endif

  // Next state and next outputs; outputs are derived from the next state so they register alongside it
  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    cnt_d         = cnt_q;
    frame_count_d = frame_count_q;
    frame_done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cam.enable) begin
          state_d = S_FSTART;
          cnt_d   = '0;
        end
      end
      S_FSTART: begin
        if (cnt_q == PW'(FVLV_DLY - 1)) begin
          state_d = S_LINE;
          x_d     = '0;
          y_d     = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_LINE: begin
        if (x_q == XW'(IMG_WIDTH - 1)) begin
          x_d   = '0;
          cnt_d = '0;
          if (y_q == YW'(IMG_HEIGHT - 1)) begin
            state_d       = S_VB;
            frame_done_d  = 1'b1;
            frame_count_d = frame_count_q + 1'b1;
          end else begin
            state_d = S_HB;
          end
        end else begin
          x_d = x_q + 1'b1;
        end
      end
      S_HB: begin
        if (cnt_q == PW'(HBLANK - 1)) begin
          state_d = S_LINE;
          x_d     = '0;
          y_d     = y_q + 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_VB: begin
        if (cnt_q == PW'(VBLANK - 1)) begin
          cnt_d   = '0;
          state_d = cam.enable ? S_FSTART : S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    ifval_d = (state_d == S_FSTART) || (state_d == S_LINE) || (state_d == S_HB);
    ilval_d = (state_d == S_LINE);
    busy_d  = (state_d != S_IDLE);
    idata_d = '0;
`ifdef D5M_CAMERA_LFSR_DATA_EN
    lfsr_d = lfsr_q;
    if (ilval_d) begin
      idata_d = DATA_WIDTH'(lfsr_q);
      lfsr_d  = {lfsr_q[10:0], lfsr_q[11] ^ lfsr_q[10] ^ lfsr_q[9] ^ lfsr_q[3]};
    end
`else
    if (ilval_d) begin
      idata_d = DATA_WIDTH'(x_d) + DATA_WIDTH'(y_d) + DATA_WIDTH'(frame_count_q);
    end
`endif
  end

  // State and position counters
  always_ff @(posedge pixclk) begin
    if (reset) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
    end
  end

  // Registered stream and status outputs
  always_ff @(posedge pixclk) begin
    if (reset) begin
      ifval_q       <= 1'b0;
      ilval_q       <= 1'b0;
      idata_q       <= '0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      ifval_q       <= ifval_d;
      ilval_q       <= ilval_d;
      idata_q       <= idata_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
    end
  end

`ifdef D5M_CAMERA_LFSR_DATA_EN
  // Payload LFSR runs across frames; only reset reseeds it
  always_ff @(posedge pixclk) begin
    if (reset) begin
      lfsr_q <= 12'hACE;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`endif

  assign cam.ifval       = ifval_q;
  assign cam.ilval       = ilval_q;
  assign cam.idata       = idata_q;
  assign cam.busy        = busy_q;
  assign cam.frame_done  = frame_done_q;
  assign cam.frame_count = frame_count_q;

endmodule

// File: tb/tb_d5m_camera_frame_gen.sv
// tb/tb_d5m_camera_frame_gen.sv - self-checking bench for d5m_camera_frame_gen
`timescale 1ns/1ps

module tb_d5m_camera_frame_gen;

  logic pixclk = 1'b0;
  logic rst1;
  logic rst2;
  int   checks   = 0;
  int   failures = 0;

  always #5 pixclk = ~pixclk;

  d5m_camera_frame_gen_if #(.DATA_WIDTH(12), .FCNT_WIDTH(16)) cam1 ();
  d5m_camera_frame_gen_if #(.DATA_WIDTH(12), .FCNT_WIDTH(2))  cam2 ();

  d5m_camera_frame_gen #(
    .DATA_WIDTH(12), .IMG_WIDTH(64), .IMG_HEIGHT(8), .FVLV_DLY(2),
    .HBLANK(4), .VBLANK(6), .FCNT_WIDTH(16)
  ) dut (
    .pixclk(pixclk), .reset(rst1), .cam(cam1)
  );

  d5m_camera_frame_gen #(
    .DATA_WIDTH(12), .IMG_WIDTH(6), .IMG_HEIGHT(3), .FVLV_DLY(1),
    .HBLANK(1), .VBLANK(1), .FCNT_WIDTH(2)
  ) dut2 (
    .pixclk(pixclk), .reset(rst2), .cam(cam2)
  );

  logic [11:0] exp1_q[$];
  logic [11:0] exp2_q[$];
  logic [11:0] obs1[$];
  logic [11:0] obs2[$];
  logic [11:0] e1, e2;
  int          blank_err1 = 0;
  int          blank_err2 = 0;

`ifdef D5M_CAMERA_LFSR_DATA_EN
  logic [11:0] lfsr1_m = 12'hACE;
  logic [11:0] lfsr2_m = 12'hACE;

  function automatic logic [11:0] lfsr_step(input logic [11:0] s);
    return {s[10:0], s[11] ^ s[10] ^ s[9] ^ s[3]};
  endfunction
`endif

  // Expected pixels of one whole frame, in raster order
  task automatic push_frame(input int which, input int f);
    int w, h;
    logic [11:0] v;
    w = (which == 1) ? 64 : 6;
    h = (which == 1) ? 8 : 3;
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
`ifdef D5M_CAMERA_LFSR_DATA_EN
        if (which == 1) begin
          v = lfsr1_m;
          lfsr1_m = lfsr_step(lfsr1_m);
        end else begin
          v = lfsr2_m;
          lfsr2_m = lfsr_step(lfsr2_m);
        end
`else
        v = 12'(x + y + ((which == 1) ? (f % 65536) : (f % 4)));
`endif
        if (which == 1) exp1_q.push_back(v);
        else            exp2_q.push_back(v);
      end
    end
  endtask

  always @(negedge pixclk) begin
    if (cam1.ilval === 1'b1) begin
      checks++;
      if (exp1_q.size() == 0) begin
        failures++;
        $display("FAIL sb1_underflow got=%0h expected=none", cam1.idata);
      end else begin
        e1 = exp1_q.pop_front();
        if (cam1.idata !== e1) begin
          failures++;
          $display("FAIL sb1_pixel got=%0h expected=%0h", cam1.idata, e1);
        end
      end
      obs1.push_back(cam1.idata);
    end else if (cam1.idata !== 12'd0) begin
      blank_err1++;
    end
  end

  always @(negedge pixclk) begin
    if (cam2.ilval === 1'b1) begin
      checks++;
      if (exp2_q.size() == 0) begin
        failures++;
        $display("FAIL sb2_underflow got=%0h expected=none", cam2.idata);
      end else begin
        e2 = exp2_q.pop_front();
        if (cam2.idata !== e2) begin
          failures++;
          $display("FAIL sb2_pixel got=%0h expected=%0h", cam2.idata, e2);
        end
      end
      obs2.push_back(cam2.idata);
    end else if (cam2.idata !== 12'd0) begin
      blank_err2++;
    end
  end

  task automatic test_reset();
    rst1 = 1'b1;
    rst2 = 1'b1;
    cam1.enable = 1'b0;
    cam2.enable = 1'b0;
    repeat (3) @(negedge pixclk);
    checks++; if (cam1.ifval !== 1'b0) begin failures++; $display("FAIL rst_ifval got=%b expected=0", cam1.ifval); end
    checks++; if (cam1.ilval !== 1'b0) begin failures++; $display("FAIL rst_ilval got=%b expected=0", cam1.ilval); end
    checks++; if (cam1.idata !== 12'd0) begin failures++; $display("FAIL rst_idata got=%0h expected=0", cam1.idata); end
    checks++; if (cam1.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b expected=0", cam1.busy); end
    checks++; if (cam1.frame_done !== 1'b0) begin failures++; $display("FAIL rst_frame_done got=%b expected=0", cam1.frame_done); end
    checks++; if (cam1.frame_count !== 16'd0) begin failures++; $display("FAIL rst_frame_count got=%0d expected=0", cam1.frame_count); end
    checks++; if (cam2.busy !== 1'b0 || cam2.ifval !== 1'b0) begin failures++; $display("FAIL rst2_idle got=%b%b expected=00", cam2.busy, cam2.ifval); end
    checks++; if (cam2.frame_count !== 2'd0) begin failures++; $display("FAIL rst2_frame_count got=%0d expected=0", cam2.frame_count); end
    rst1 = 1'b0;
    rst2 = 1'b0;
`ifdef D5M_CAMERA_LFSR_DATA_EN
    lfsr1_m = 12'hACE;
    lfsr2_m = 12'hACE;
`endif
    @(negedge pixclk);
  endtask

  // Two continuous frames, enable dropped during line 4 of the second one
  task automatic test_frame_timing();
    int p, f, r, mism, first_bad, first_il, efc;
    int rises[$];
    logic e_if, e_il, e_fd, e_busy, prev_if;
    logic [11:0] got, want;
    exp1_q.delete();
    obs1.delete();
    blank_err1 = 0;
    push_frame(1, 0);
    push_frame(1, 1);
    mism = 0; first_bad = -1; first_il = -1; prev_if = 1'b0;
    cam1.enable = 1'b1;
    for (int t = 1; t <= 1160; t++) begin
      @(negedge pixclk);
      p = t - 1; f = p / 548; r = p % 548;
      if (f >= 2) begin
        e_if = 1'b0; e_il = 1'b0; e_fd = 1'b0; e_busy = 1'b0;
      end else begin
        e_if = (r < 542);
        e_il = (r >= 2) && (r < 542) && (((r - 2) % 68) < 64);
        e_fd = (r == 542);
        e_busy = 1'b1;
      end
      efc = (t >= 543 ? 1 : 0) + (t >= 1091 ? 1 : 0);
      if (cam1.ifval !== e_if || cam1.ilval !== e_il || cam1.frame_done !== e_fd ||
          cam1.busy !== e_busy || cam1.frame_count !== 16'(efc)) begin
        mism++;
        if (first_bad < 0) first_bad = t;
      end
      if (cam1.ilval === 1'b1 && first_il < 0) first_il = t;
      if (cam1.ifval === 1'b1 && prev_if === 1'b0) rises.push_back(t);
      prev_if = cam1.ifval;
      if (t == 830) cam1.enable = 1'b0;
    end
    checks++; if (mism != 0) begin failures++; $display("FAIL timing_trace mismatching_cycles=%0d first_at=%0d expected=0", mism, first_bad); end
    checks++; if (first_il != 3) begin failures++; $display("FAIL first_ilval got=%0d expected=3", first_il); end
    checks++; if (rises.size() != 2) begin failures++; $display("FAIL ifval_rises got=%0d expected=2", rises.size()); end
    else begin
      checks++; if (rises[0] != 1) begin failures++; $display("FAIL ifval_first_rise got=%0d expected=1", rises[0]); end
      checks++; if (rises[1] - rises[0] != 548) begin failures++; $display("FAIL frame_period got=%0d expected=548", rises[1] - rises[0]); end
    end
    checks++; if (exp1_q.size() != 0) begin failures++; $display("FAIL timing_pixels_left got=%0d expected=0", exp1_q.size()); end
    checks++; if (obs1.size() != 1024) begin failures++; $display("FAIL timing_pixel_count got=%0d expected=1024", obs1.size()); end
    checks++; if (blank_err1 != 0) begin failures++; $display("FAIL idata_blank nonzero_cycles=%0d expected=0", blank_err1); end
    checks++; if (cam1.frame_count !== 16'd2) begin failures++; $display("FAIL timing_frame_count got=%0d expected=2", cam1.frame_count); end
`ifdef D5M_CAMERA_LFSR_DATA_EN
    got = (obs1.size() > 0) ? obs1[0] : 12'hxxx;
    checks++; if (got !== 12'hACE) begin failures++; $display("FAIL lfsr_px0 got=%0h expected=ace", got); end
    got = (obs1.size() > 1) ? obs1[1] : 12'hxxx;
    checks++; if (got !== 12'h59D) begin failures++; $display("FAIL lfsr_px1 got=%0h expected=59d", got); end
    want = 12'hACE;
    for (int i = 0; i < 512; i++) want = lfsr_step(want);
    got = (obs1.size() > 512) ? obs1[512] : 12'hxxx;
    checks++; if (got !== want) begin failures++; $display("FAIL lfsr_frame1_px0 got=%0h expected=%0h", got, want); end
`else
    got = (obs1.size() > 133) ? obs1[133] : 12'hxxx;
    checks++; if (got !== 12'd7) begin failures++; $display("FAIL ramp_f0_y2_x5 got=%0d expected=7", got); end
    got = (obs1.size() > 645) ? obs1[645] : 12'hxxx;
    checks++; if (got !== 12'd8) begin failures++; $display("FAIL ramp_f1_y2_x5 got=%0d expected=8", got); end
    want = 12'd0;
`endif
  endtask

  // Reset mid-line 3, then one restarted frame with enable dropped during line 4
  task automatic test_reset_midframe();
    int fd_cnt, late_if, first_if, first_il, busy_at_548, busy_at_549;
    logic [11:0] got;
    exp1_q.delete();
    obs1.delete();
    push_frame(1, 2);
    cam1.enable = 1'b1;
    for (int t = 1; t <= 217; t++) @(negedge pixclk);
    rst1 = 1'b1;
    @(negedge pixclk);
    checks++; if (cam1.ifval !== 1'b0 || cam1.ilval !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b%b expected=00", cam1.ifval, cam1.ilval); end
    checks++; if (cam1.idata !== 12'd0) begin failures++; $display("FAIL midrst_idata got=%0h expected=0", cam1.idata); end
    checks++; if (cam1.busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b expected=0", cam1.busy); end
    checks++; if (cam1.frame_count !== 16'd0) begin failures++; $display("FAIL midrst_frame_count got=%0d expected=0", cam1.frame_count); end
    rst1 = 1'b0;
    exp1_q.delete();
    obs1.delete();
    blank_err1 = 0;
`ifdef D5M_CAMERA_LFSR_DATA_EN
    lfsr1_m = 12'hACE;
`endif
    push_frame(1, 0);
    fd_cnt = 0; late_if = 0; first_if = -1; first_il = -1; busy_at_548 = -1; busy_at_549 = -1;
    for (int t = 1; t <= 620; t++) begin
      @(negedge pixclk);
      if (cam1.ifval === 1'b1 && first_if < 0) first_if = t;
      if (cam1.ilval === 1'b1 && first_il < 0) first_il = t;
      if (cam1.frame_done === 1'b1) fd_cnt++;
      if (t >= 549 && cam1.ifval !== 1'b0) late_if++;
      if (t == 548) busy_at_548 = int'(cam1.busy);
      if (t == 549) busy_at_549 = int'(cam1.busy);
      if (t == 280) cam1.enable = 1'b0;
    end
    checks++; if (first_if != 1) begin failures++; $display("FAIL restart_ifval_at got=%0d expected=1", first_if); end
    checks++; if (first_il != 3) begin failures++; $display("FAIL restart_ilval_at got=%0d expected=3", first_il); end
    checks++; if (fd_cnt != 1) begin failures++; $display("FAIL drop_frame_done_pulses got=%0d expected=1", fd_cnt); end
    checks++; if (cam1.frame_count !== 16'd1) begin failures++; $display("FAIL drop_frame_count got=%0d expected=1", cam1.frame_count); end
    checks++; if (exp1_q.size() != 0) begin failures++; $display("FAIL drop_pixels_left got=%0d expected=0", exp1_q.size()); end
    checks++; if (obs1.size() != 512) begin failures++; $display("FAIL drop_pixel_count got=%0d expected=512", obs1.size()); end
    checks++; if (busy_at_548 != 1 || busy_at_549 != 0) begin failures++; $display("FAIL drop_busy_edge got=%0d%0d expected=10", busy_at_548, busy_at_549); end
    checks++; if (late_if != 0) begin failures++; $display("FAIL drop_late_ifval got=%0d expected=0", late_if); end
    checks++; if (blank_err1 != 0) begin failures++; $display("FAIL drop_idata_blank nonzero_cycles=%0d expected=0", blank_err1); end
    got = (obs1.size() > 0) ? obs1[0] : 12'hxxx;
`ifdef D5M_CAMERA_LFSR_DATA_EN
    checks++; if (got !== 12'hACE) begin failures++; $display("FAIL restart_px0 got=%0h expected=ace", got); end
`else
    checks++; if (got !== 12'd0) begin failures++; $display("FAIL restart_px0 got=%0h expected=0", got); end
`endif
  endtask

  // Minimum-size configuration with 2-bit frame counter over five frames
  task automatic test_fcnt_wrap();
    int pulses, diff_bad, last_t;
    int fcs[$];
    int want_fc[5] = '{1, 2, 3, 0, 1};
    logic [11:0] got;
    exp2_q.delete();
    obs2.delete();
    blank_err2 = 0;
    for (int f = 0; f < 5; f++) push_frame(2, f);
    pulses = 0; diff_bad = 0; last_t = 0;
    cam2.enable = 1'b1;
    for (int t = 1; t <= 300 && pulses < 5; t++) begin
      @(negedge pixclk);
      if (cam2.frame_done === 1'b1) begin
        fcs.push_back(int'(cam2.frame_count));
        if (t - last_t != 22) diff_bad++;
        last_t = t;
        pulses++;
        if (pulses == 5) cam2.enable = 1'b0;
      end
    end
    repeat (5) @(negedge pixclk);
    checks++; if (pulses != 5) begin failures++; $display("FAIL wrap_pulses got=%0d expected=5", pulses); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= fcs.size()) begin failures++; $display("FAIL wrap_fc%0d got=none expected=%0d", i, want_fc[i]); end
      else if (fcs[i] != want_fc[i]) begin failures++; $display("FAIL wrap_fc%0d got=%0d expected=%0d", i, fcs[i], want_fc[i]); end
    end
    checks++; if (diff_bad != 0) begin failures++; $display("FAIL wrap_period bad_periods=%0d expected=0", diff_bad); end
    checks++; if (exp2_q.size() != 0) begin failures++; $display("FAIL wrap_pixels_left got=%0d expected=0", exp2_q.size()); end
    checks++; if (cam2.busy !== 1'b0) begin failures++; $display("FAIL wrap_busy got=%b expected=0", cam2.busy); end
    checks++; if (blank_err2 != 0) begin failures++; $display("FAIL wrap_idata_blank nonzero_cycles=%0d expected=0", blank_err2); end
`ifdef D5M_CAMERA_LFSR_DATA_EN
    got = (obs2.size() > 0) ? obs2[0] : 12'hxxx;
    checks++; if (got !== 12'hACE) begin failures++; $display("FAIL wrap_lfsr_px0 got=%0h expected=ace", got); end
`else
    got = (obs2.size() > 71) ? obs2[71] : 12'hxxx;
    checks++; if (got !== 12'd10) begin failures++; $display("FAIL ramp_f3_y2_x5 got=%0d expected=10", got); end
    got = (obs2.size() > 89) ? obs2[89] : 12'hxxx;
    checks++; if (got !== 12'd7) begin failures++; $display("FAIL ramp_f4_wrap_y2_x5 got=%0d expected=7", got); end
`endif
  endtask

  initial begin
    test_reset();
    test_frame_timing();
    test_reset_midframe();
    test_fcnt_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
